// File: rtl/fetch_2_pkg.sv
// Shared constants and latch layout for the second fetch stage.
// A line latch holds one 16-byte I$ line plus its valid and exception tags.
package fetch_2_pkg;

  localparam int LINE_BYTES = 32'sd16;
  localparam int LINE_W     = 32'sd8 * LINE_BYTES;
  localparam int PTR_W      = 32'sd5;
  localparam int LEN_W      = 32'sd4;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              v;
    logic              x;
  } line_latch_t;

  // True when an advance moves the pointer into the other latch.
  function automatic logic crosses_line(input logic [PTR_W-1:0] old_ptr,
                                        input logic [PTR_W-1:0] new_ptr);
    return old_ptr[PTR_W-1] ^ new_ptr[PTR_W-1];
  endfunction

endpackage

// File: rtl/fetch_2_f2_byte_rotator.sv
// 256-to-128 byte-granular right shifter for the decode window.
// Four mux stages, one per offset bit, shifting by 1, 2, 4 and 8 bytes.
module f2_byte_rotator
  import fetch_2_pkg::*;
(
  input  logic [2*LINE_W-1:0] data_in,
  input  logic [3:0]          shift,
  output logic [LINE_W-1:0]   data_out
);

  logic [2*LINE_W-1:0] stage1_s;
  logic [2*LINE_W-1:0] stage2_s;
  logic [2*LINE_W-1:0] stage3_s;
  logic [2*LINE_W-1:0] stage4_s;

  assign stage1_s = shift[0] ? (data_in  >> 32'd8)  : data_in;
  assign stage2_s = shift[1] ? (stage1_s >> 32'd16) : stage1_s;
  assign stage3_s = shift[2] ? (stage2_s >> 32'd32) : stage2_s;
  assign stage4_s = shift[3] ? (stage3_s >> 32'd64) : stage3_s;
  assign data_out = stage4_s[LINE_W-1:0];

endmodule

// File: rtl/kogeAdder.sv
// Kogge-Stone prefix adder used for the fetch byte pointer.
// The carry-in is folded into the bit-0 generate so the prefix tree yields every carry.
module kogeAdder #(
  parameter int WIDTH = 32'sd5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  localparam int LEVELS = $clog2(WIDTH);

  // Prefix tree: each level doubles the span of the group generate/propagate terms.
  always_comb begin
    logic [WIDTH-1:0] g_v;
    logic [WIDTH-1:0] p_v;
    logic [WIDTH-1:0] g_n;
    logic [WIDTH-1:0] p_n;
    g_v = a & b;
    p_v = a ^ b;
    g_v[0] = g_v[0] | (p_v[0] & cin);
    for (int l = 32'sd0; l < LEVELS; l++) begin
      g_n = g_v;
      p_n = p_v;
      for (int i = 32'sd0; i < WIDTH; i++) begin
        if (i >= (32'sd1 << l)) begin
          g_n[i] = g_v[i] | (p_v[i] & g_v[i - (32'sd1 << l)]);
          p_n[i] = p_v[i] & p_v[i - (32'sd1 << l)];
        end else begin
          g_n[i] = g_v[i];
          p_n[i] = p_v[i];
        end
      end
      g_v = g_n;
      p_v = p_n;
    end
    sum = (a ^ b) ^ {g_v[WIDTH-2:0], cin};
  end

endmodule

// File: rtl/fetch_2.sv
// Second fetch stage: even/odd line latches, byte pointer and 16-byte decode window.
// Load pulses feed back to fetch_1 as its FIP register enables.
module fetch_2
  import fetch_2_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LINE_W-1:0] line_even_in,
  input  logic [LINE_W-1:0] line_odd_in,
  input  logic              cache_miss_even,
  input  logic              cache_miss_odd,
  input  logic              evenW,
  input  logic              oddW,
  input  logic              exc_even,
  input  logic              exc_odd,
  input  logic              flush,
  input  logic [PTR_W-1:0]  flush_offset,
  input  logic              consume_valid,
  input  logic [LEN_W-1:0]  consume_len,
  output logic              even_latch_was_loaded,
  output logic              odd_latch_was_loaded,
  output logic              flush_done,
  output logic              window_valid,
  output logic [LINE_W-1:0] window_bytes,
  output logic              window_exc,
  output logic [PTR_W-1:0]  ptr_out
);

  line_latch_t       even_r;
  line_latch_t       odd_r;
  line_latch_t       cur_s;
  line_latch_t       nxt_s;
  logic [PTR_W-1:0]  ptr_r;
  logic [PTR_W-1:0]  ptr_sum_s;
  logic [3:0]        off_s;
  logic              win_valid_s;
  logic              consume_s;
  logic              cross_s;
  logic              even_load_s;
  logic              odd_load_s;
  logic [LINE_W-1:0] rot_s;

  kogeAdder #(.WIDTH(PTR_W)) u_ptr_add (
    .a   (ptr_r),
    .b   ({1'b0, consume_len}),
    .cin (1'b0),
    .sum (ptr_sum_s)
  );

  f2_byte_rotator u_rot (
    .data_in  ({nxt_s.data, cur_s.data}),
    .shift    (off_s),
    .data_out (rot_s)
  );

  // Current/next latch selection, window qualification, consume and load enables.
  always_comb begin
    if (ptr_r[4]) begin
      cur_s = odd_r;
      nxt_s = even_r;
    end else begin
      cur_s = even_r;
      nxt_s = odd_r;
    end
    off_s       = ptr_r[3:0];
    win_valid_s = reset & cur_s.v & ((off_s == 4'd0) | nxt_s.v) & ~flush;
    consume_s   = consume_valid & win_valid_s & (consume_len != 4'd0);
    cross_s     = crosses_line(ptr_r, ptr_sum_s);
    // During flush the registered V is about to be cleared, so only miss/W gate the load.
    even_load_s = reset & ~cache_miss_even & ~evenW & (flush | ~even_r.v);
    odd_load_s  = reset & ~cache_miss_odd  & ~oddW  & (flush | ~odd_r.v);
  end

  assign even_latch_was_loaded = even_load_s;
  assign odd_latch_was_loaded  = odd_load_s;
  assign flush_done            = flush & even_load_s & odd_load_s;
  assign window_valid          = win_valid_s;
  assign window_bytes          = win_valid_s ? rot_s : {LINE_W{1'b0}};
  assign window_exc            = win_valid_s & (cur_s.x | ((off_s != 4'd0) & nxt_s.x));
  assign ptr_out               = ptr_r;

  // Pointer and latch state; a latch drained by a crossing consume refills next cycle at the earliest.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_r  <= {PTR_W{1'b0}};
      even_r <= {($bits(line_latch_t)){1'b0}};
      odd_r  <= {($bits(line_latch_t)){1'b0}};
    end else begin
      if (flush) begin
        ptr_r <= flush_offset;
      end else if (consume_s) begin
        ptr_r <= ptr_sum_s;
      end else begin
        ptr_r <= ptr_r;
      end

      if (even_load_s) begin
        even_r.data <= line_even_in;
        even_r.v    <= 1'b1;
        even_r.x    <= exc_even;
      end else if (flush | (consume_s & cross_s & ~ptr_r[4])) begin
        even_r.v <= 1'b0;
      end else begin
        even_r <= even_r;
      end

      if (odd_load_s) begin
        odd_r.data <= line_odd_in;
        odd_r.v    <= 1'b1;
        odd_r.x    <= exc_odd;
      end else if (flush | (consume_s & cross_s & ptr_r[4])) begin
        odd_r.v <= 1'b0;
      end else begin
        odd_r <= odd_r;
      end
    end
  end

endmodule

// File: tb/tb_fetch_2.sv
// Scoreboard bench for fetch_2: stimulus queues expected windows, a negedge monitor
// pops one whenever decode presents consume_valid against a valid window.
module tb_fetch_2;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] line_even_in, line_odd_in;
  logic         cache_miss_even, cache_miss_odd, evenW, oddW, exc_even, exc_odd;
  logic         flush;
  logic [4:0]   flush_offset;
  logic         consume_valid;
  logic [3:0]   consume_len;
  logic         even_latch_was_loaded, odd_latch_was_loaded, flush_done;
  logic         window_valid, window_exc;
  logic [127:0] window_bytes;
  logic [4:0]   ptr_out;

  typedef struct {
    logic [4:0]   ptr;
    logic [127:0] bytes;
    logic         exc;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [127:0] exp_even, exp_odd;

  fetch_2 dut (
    .clk(clk), .reset(reset),
    .line_even_in(line_even_in), .line_odd_in(line_odd_in),
    .cache_miss_even(cache_miss_even), .cache_miss_odd(cache_miss_odd),
    .evenW(evenW), .oddW(oddW), .exc_even(exc_even), .exc_odd(exc_odd),
    .flush(flush), .flush_offset(flush_offset),
    .consume_valid(consume_valid), .consume_len(consume_len),
    .even_latch_was_loaded(even_latch_was_loaded), .odd_latch_was_loaded(odd_latch_was_loaded),
    .flush_done(flush_done), .window_valid(window_valid), .window_bytes(window_bytes),
    .window_exc(window_exc), .ptr_out(ptr_out)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk_line(input logic [7:0] base);
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[8*i +: 8] = base + 8'(i);
    return l;
  endfunction

  // Window = 16 consecutive bytes of the 32-byte even|odd ring starting at p.
  function automatic logic [127:0] exp_win(input logic [4:0] p);
    logic [127:0] w;
    logic [4:0]   k;
    for (int j = 0; j < 16; j++) begin
      k = p + 5'(j);
      w[8*j +: 8] = k[4] ? exp_odd[8*k[3:0] +: 8] : exp_even[8*k[3:0] +: 8];
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_win(input logic [4:0] p, input logic exc, input logic [3:0] len);
    exp_t e;
    e.ptr   = p;
    e.bytes = exp_win(p);
    e.exc   = exc;
    sb_q.push_back(e);
    consume_valid = 1'b1;
    consume_len   = len;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted window is matched against the oldest expectation.
  always @(negedge clk) begin
    if (window_valid === 1'b1 && consume_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got window at ptr %h, expected none", ptr_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("win_ptr", 128'(ptr_out), 128'(e.ptr));
        chk("win_bytes", window_bytes, e.bytes);
        chk("win_exc", 128'(window_exc), 128'(e.exc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; line_even_in = '0; line_odd_in = '0;
    cache_miss_even = 1'b0; cache_miss_odd = 1'b0; evenW = 1'b1; oddW = 1'b0;
    exc_even = 1'b0; exc_odd = 1'b0; flush = 1'b0; flush_offset = 5'd0;
    consume_valid = 1'b1; consume_len = 4'd3;
    tick; tick;
    @(negedge clk);
    chk("rst_valid", 128'(window_valid), 128'd0);
    chk("rst_bytes", window_bytes, 128'd0);
    chk("rst_exc", 128'(window_exc), 128'd0);
    chk("rst_ptr", 128'(ptr_out), 128'd0);
    chk("rst_even_ld", 128'(even_latch_was_loaded), 128'd0);
    chk("rst_odd_ld", 128'(odd_latch_was_loaded), 128'd0);
    chk("rst_fdone", 128'(flush_done), 128'd0);
    tick;

    // Reset released with idle hits: both latches load, window follows one cycle later.
    reset = 1'b1; evenW = 1'b0; consume_valid = 1'b0;
    line_even_in = mk_line(8'h00); line_odd_in = mk_line(8'h10);
    exp_even = line_even_in; exp_odd = line_odd_in;
    @(negedge clk);
    chk("c1_even_ld", 128'(even_latch_was_loaded), 128'd1);
    chk("c1_odd_ld", 128'(odd_latch_was_loaded), 128'd1);
    chk("c1_valid", 128'(window_valid), 128'd0);
    tick;
    push_win(5'h00, 1'b0, 4'd12);
    @(negedge clk);
    chk("c2_window_is_even", window_bytes, mk_line(8'h00));
    chk("c2_even_ld", 128'(even_latch_was_loaded), 128'd0);
    tick;

    // ptr 0x0C + 6 crosses into odd and frees even.
    push_win(5'h0C, 1'b0, 4'd6);
    line_even_in = mk_line(8'h20);
    tick;
    consume_valid = 1'b1; consume_len = 4'd4;
    @(negedge clk);
    chk("x1_ptr", 128'(ptr_out), 128'h12);
    chk("x1_even_ld", 128'(even_latch_was_loaded), 128'd1);
    chk("x1_odd_ld", 128'(odd_latch_was_loaded), 128'd0);
    chk("x1_valid", 128'(window_valid), 128'd0);
    tick;
    exp_even = mk_line(8'h20);
    push_win(5'h12, 1'b0, 4'd12);
    @(negedge clk);
    chk("x1_ptr_held", 128'(ptr_out), 128'h12);
    tick;

    // ptr 0x1E + 5 wraps to 0x03 and frees odd.
    push_win(5'h1E, 1'b0, 4'd5);
    line_odd_in = mk_line(8'h30);
    tick;
    consume_valid = 1'b0;
    @(negedge clk);
    chk("w_ptr", 128'(ptr_out), 128'h03);
    chk("w_odd_ld", 128'(odd_latch_was_loaded), 128'd1);
    chk("w_even_ld", 128'(even_latch_was_loaded), 128'd0);
    chk("w_valid", 128'(window_valid), 128'd0);
    tick;
    exp_odd = mk_line(8'h30);
    push_win(5'h03, 1'b0, 4'd0);
    tick;

    // Flush to 0x17: even misses first, then both hit.
    consume_valid = 1'b1; consume_len = 4'd5;
    flush = 1'b1; flush_offset = 5'h17; cache_miss_even = 1'b1;
    line_even_in = mk_line(8'h40); line_odd_in = mk_line(8'h50);
    @(negedge clk);
    chk("f1_fdone", 128'(flush_done), 128'd0);
    chk("f1_odd_ld", 128'(odd_latch_was_loaded), 128'd1);
    chk("f1_even_ld", 128'(even_latch_was_loaded), 128'd0);
    chk("f1_valid", 128'(window_valid), 128'd0);
    tick;
    cache_miss_even = 1'b0;
    @(negedge clk);
    chk("f2_fdone", 128'(flush_done), 128'd1);
    chk("f2_ptr", 128'(ptr_out), 128'h17);
    tick;
    flush = 1'b0;
    exp_even = mk_line(8'h40); exp_odd = mk_line(8'h50);
    push_win(5'h17, 1'b0, 4'd0);
    @(negedge clk);
    chk("f3_fdone", 128'(flush_done), 128'd0);
    chk("f3_odd_ld", 128'(odd_latch_was_loaded), 128'd0);
    tick;

    // Exception tag on the odd line: seen at 0x08, not at 0x00.
    consume_valid = 1'b0;
    flush = 1'b1; flush_offset = 5'h08; exc_odd = 1'b1;
    line_even_in = mk_line(8'h60); line_odd_in = mk_line(8'h70);
    @(negedge clk);
    chk("e1_fdone", 128'(flush_done), 128'd1);
    tick;
    flush = 1'b0; exc_odd = 1'b0;
    exp_even = mk_line(8'h60); exp_odd = mk_line(8'h70);
    push_win(5'h08, 1'b1, 4'd0);
    tick;
    consume_valid = 1'b0;
    flush = 1'b1; flush_offset = 5'h00; exc_odd = 1'b1;
    tick;
    flush = 1'b0; exc_odd = 1'b0;
    push_win(5'h00, 1'b0, 4'd5);
    tick;

    // Reset during a consume with evenW high clears everything and blocks loads.
    reset = 1'b0; evenW = 1'b1; consume_valid = 1'b1; consume_len = 4'd5;
    @(negedge clk);
    chk("r_valid_in_rst", 128'(window_valid), 128'd0);
    chk("r_even_ld", 128'(even_latch_was_loaded), 128'd0);
    chk("r_odd_ld", 128'(odd_latch_was_loaded), 128'd0);
    tick;
    @(negedge clk);
    chk("r_ptr", 128'(ptr_out), 128'd0);
    chk("r_bytes", window_bytes, 128'd0);
    chk("r_exc", 128'(window_exc), 128'd0);
    tick;
    reset = 1'b1; consume_valid = 1'b0;
    @(negedge clk);
    chk("r_even_ld_w", 128'(even_latch_was_loaded), 128'd0);
    chk("r_odd_ld_w", 128'(odd_latch_was_loaded), 128'd1);
    chk("r_valid_empty", 128'(window_valid), 128'd0);
    tick;
    evenW = 1'b0;
    @(negedge clk);
    chk("r_even_ld_ok", 128'(even_latch_was_loaded), 128'd1);
    tick;
    push_win(5'h00, 1'b0, 4'd0);
    tick;
    consume_valid = 1'b0;
    tick; tick;
    chk("sb_drained", 128'(sb_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_2.md
# fetch_2

Second fetch stage. Captures the even and odd 16-byte lines produced by `fetch_1` into two line latches and presents a 16-byte, byte-aligned instruction window to decode. Advances a byte pointer by the length decode consumes. Returns the `even_latch_was_loaded` / `odd_latch_was_loaded` pulses that step `fetch_1`'s FIP registers.

## Interface
- No parameters. Line width is fixed at 128 bits; window width is fixed at 16 bytes.
- `clk` in 1: core clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low.
- `line_even_in`, `line_odd_in` in 128: lines from the I$ banks; byte i is bits [8i+7:8i].
- `cache_miss_even`, `cache_miss_odd` in 1: line input invalid this cycle.
- `evenW`, `oddW` in 1: bank is writing a fill; line input invalid.
- `exc_even`, `exc_odd` in 1: OR of TLB miss and protection exception for that side.
- `flush` in 1: init/resteer/taken branch. Held by upstream until `flush_done`.
- `flush_offset` in 5: target address bits [4:0].
- `consume_valid` in 1: decode accepts bytes this cycle.
- `consume_len` in 4: bytes consumed, 1..15; 0 is ignored.
- `even_latch_was_loaded`, `odd_latch_was_loaded` out 1: latch captured this cycle. Combinational.
- `flush_done` out 1: both latches captured during flush. Combinational.
- `window_valid` out 1: `window_bytes` is usable.
- `window_bytes` out 128: 16 bytes starting at the pointer.
- `window_exc` out 1: window touches a latch tagged with an exception.
- `ptr_out` out 5: current pointer, for debug and verification.

## Operation
- State:
  - even latch: 128 data bits + V + X.
  - odd latch: same layout.
  - 5-bit pointer `ptr`. `ptr[4]` selects the current latch (0 = even); `ptr[3:0]` is the byte offset.
- Load, normal cycle:
  - A latch loads iff its registered V=0, its miss input=0, its W input=0, and `flush`=0.
  - On load: V=1, X=`exc_*`.
  - `*_latch_was_loaded` equals the load enable.
- Flush cycle (`flush`=1):
  - Both V are cleared; `ptr`=`flush_offset`; `consume_valid` is ignored.
  - Each side then loads if its miss=0 and W=0, overriding the clear, and asserts its `was_loaded`.
  - `flush_done`=1 iff both sides load this cycle.
  - Upstream holds `flush` until `flush_done`; every flush cycle re-clears both latches.
- Window:
  - cur = latch selected by `ptr[4]`; nxt = the other latch.
  - `window_bytes` = ({nxt, cur} >> 8·`ptr[3:0]`)[127:0].
  - `window_valid` = cur.V & (`ptr[3:0]`==0 | nxt.V) & !`flush`.
  - `window_exc` = cur.X | (`ptr[3:0]`≠0 & nxt.X), qualified by `window_valid`.
- Consume:
  - Takes effect iff `consume_valid` & `window_valid` & `consume_len`≠0.
  - `ptr` ← `ptr` + `consume_len`, 5-bit, mod 32.
  - If `ptr[4]` changes, cur.V ← 0. At most one boundary is crossed, since 15+15 < 32.
  - A latch freed by a consume is not reloaded in the same cycle.
- A consume with `window_valid`=0 is ignored; the pointer holds.
- `window_bytes`=0 whenever `window_valid`=0.

## Timing
- Reset (`reset`=0 at an edge):
  - ptr=0; both V=0; both X=0; data=0.
  - All outputs 0.
  - Reset has priority over `flush`, load and consume.
- Load-to-window latency: 1 cycle after the latch captures.
- `was_loaded` is asserted in the same cycle as the capture edge. `fetch_1` uses it as its FIP register load enable.
- Consume-to-refill:
  - Crossing consume at edge N clears V.
  - Reload enable can assert in cycle N+1; window valid again at N+2.
- Throughput: one consume per cycle; a 16-byte line sustains with no bubble only if nxt refills before cur is drained.

## Structure
- Shared package constants: `LINE_BYTES`=16, `PTR_W`=5, `LEN_W`=4.
- One sub-module, `f2_byte_rotator`: 256→128 byte-granular right shift, built from a log-depth mux tree on `ptr[3:0]`.
- Latches, pointer adder and valid logic stay in `fetch_2`. Adder is `kogeAdder` WIDTH 5.

## Test plan
- Reset then idle hits:
  - Cycle 1: both `was_loaded`=1.
  - Cycle 2: `window_valid`=1, `window_bytes`=even line, `ptr_out`=0.
- ptr=0x0C, consume_len=6 with both latches valid:
  - ptr→0x12; even V cleared.
  - Next cycle: `even_latch_was_loaded`=1.
  - Window then starts at odd byte 2.
- ptr=0x1E, consume_len=5:
  - Wraps to 0x03; odd V cleared.
  - Window = even bytes 3..15 followed by odd bytes 0..2 after refill.
- Flush to offset 0x17:
  - Cycle 1: odd hit, even miss → `flush_done`=0.
  - Cycle 2: both hit → `flush_done`=1.
  - Cycle 3: window = odd bytes 7..15 + even 0..6.
- `exc_odd`=1 on load, ptr=0x08:
  - `window_exc`=1.
  - At ptr=0x00 with even clean, `window_exc`=0.
- `reset` low during a consume while `evenW`=1: all state zero next cycle; no load.
